prog_loader: RTL and testbench
==============================

Name: prog_loader

Overview:
- Instruction-side responder for the processor's fetch interface.
- Owns a 16-bit instruction memory and receives a program image over a byte-wide valid/ready stream from the host link.
- Holds the core in reset while loading, then serves `instruction` combinationally from the core's `pc`.
- Sits between the host link and the processor's `pc`/`instruction`/`rst` ports.

Parameters:
- BITNESS, 64, width of the core's `pc` (matches the core word width).
- DEPTH_LOG2, 10, log2 of instruction memory depth in 16-bit words.
- FILL, 16'h0000, instruction returned for any `pc` at or beyond the loaded length.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- load_start  input  1  one-cycle pulse; begins a new program load.
- in_valid  input  1  host byte valid.
- in_data  input  8  host byte.
- in_ready  output  1  loader accepts a byte this cycle.
- pc  input  BITNESS  core program counter.
- instruction  output  16  instruction at `pc`; combinational, same cycle.
- core_rst  output  1  reset to the processor; registered.
- loaded_len  output  16  number of instructions in the current image.
- overflow  output  1  sticky: image length exceeded memory depth.
- busy  output  1  high while not in RUN.

Behaviour:
- Reset (`rst`=1 at posedge):
  - state=IDLE, core_rst=1, in_ready=0, loaded_len=0, overflow=0, busy=1.
  - Byte counter and write pointer cleared. Memory contents are not cleared.
- Handshake: a byte transfers on a posedge where in_valid && in_ready. in_ready is a registered function of state only:
  - 1 in LEN_LO, LEN_HI, INS_LO and INS_HI.
  - 0 in IDLE and RUN.
- States and transitions:
  - IDLE: core_rst=1. load_start -> LEN_LO.
  - LEN_LO: accepted byte -> len[7:0]; -> LEN_HI.
  - LEN_HI: accepted byte -> len[15:8].
    - If len==0: -> RUN, loaded_len=0.
    - Otherwise: wptr=0; -> INS_LO.
  - INS_LO: accepted byte latched as low byte; -> INS_HI.
  - INS_HI: accepted byte forms word {byte, low}.
    - If wptr < 2**DEPTH_LOG2: write the word to mem[wptr]. Otherwise discard it and set overflow=1.
    - Then wptr++. If wptr+1==len: -> RUN, loaded_len=min(len, 2**DEPTH_LOG2). Else -> INS_LO.
  - RUN: core_rst=0, busy=0. load_start -> LEN_LO with core_rst=1 and busy=1 on the next cycle, overflow cleared.
- load_start in any state other than IDLE or RUN is ignored. A load in progress always completes.
- Image bytes are little-endian: length first (2 bytes), then 2*len instruction bytes.
- Latency:
  - core_rst deasserts on the posedge after the cycle in which the final byte is accepted, or after the LEN_HI byte when len==0.
  - The core therefore first fetches pc=0 on the cycle after that posedge.
- Fetch:
  - instruction = mem[pc[DEPTH_LOG2-1:0]] when pc < loaded_len, compared at full BITNESS width (upper pc bits nonzero => out of range).
  - Otherwise instruction = FILL.
  - Combinational read, zero cycles from `pc` change.
- During a reload, instruction reflects the new loaded_len only after RUN is re-entered. loaded_len updates in the same posedge that enters RUN.
- Overflow: the loader still consumes all 2*len bytes so the host stream stays aligned. loaded_len saturates at 2**DEPTH_LOG2.
- rst asserted mid-load aborts to IDLE. Bytes already written remain in memory but are unreachable because loaded_len=0.

Test Plan:
1. Reset, load_start, stream 03 00 34 12 78 56 BC 9A.
   - in_ready high for 8 accepted bytes.
   - core_rst falls one cycle after the last byte.
   - pc=0/1/2 -> 16'h1234/16'h5678/16'h9ABC; pc=3 -> FILL.
   - loaded_len=3.
2. Host throttling: in_valid toggled every other cycle with the same image.
   - Identical memory contents.
   - No byte duplicated or lost; overflow=0.
3. Zero-length image 00 00.
   - RUN entered after the second byte; core_rst=0.
   - Every pc returns FILL; loaded_len=0.
4. DEPTH_LOG2=2, len=6, words 0001..0006.
   - mem holds 0001..0004; overflow=1; loaded_len=4.
   - All 12 data bytes accepted; pc=4 -> FILL.
5. In RUN, pulse load_start and stream 01 00 EF BE.
   - core_rst reasserts the next cycle.
   - After reload, pc=0 -> 16'hBEEF, pc=1 -> FILL; overflow cleared.
6. Assert rst after 3 bytes of image 1.
   - State IDLE, core_rst=1, loaded_len=0, in_ready=0.
   - A subsequent full load succeeds normally.
   - pc with bit 63 set -> FILL.

Source files
------------

// File: rtl/prog_loader.sv
// Program loader and instruction-fetch responder.
// Receives a little-endian program image over a byte stream:
// a 16-bit length, then that many 16-bit instruction words.
// The image goes into instruction memory while the core is held in
// reset. Afterwards the core is released and fetches are served
// combinationally from its program counter.
module prog_loader #(
   parameter int          BITNESS    = 64,
   parameter int          DEPTH_LOG2 = 10,
   parameter logic [15:0] FILL       = 16'h0000
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               load_start,
   input  logic               in_valid,
   input  logic [7:0]         in_data,
   output logic               in_ready,
   input  logic [BITNESS-1:0] pc,
   output logic [15:0]        instruction,
   output logic               core_rst,
   output logic [15:0]        loaded_len,
   output logic               overflow,
   output logic               busy
);

   // Memory depth, held one bit wider so that a depth of 2**16 still fits.
   localparam logic [16:0] DEPTH_W = 17'(1) << DEPTH_LOG2;
   // The fetch range check runs at the wider of the pc width and the length width.
   localparam int CW = (BITNESS > 16) ? BITNESS : 16;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LEN_LO,
      S_LEN_HI,
      S_INS_LO,
      S_INS_HI,
      S_RUN
   } state_t;

   state_t      state_reg;
   logic [15:0] len_reg;
   logic [15:0] wptr_reg;
   logic [7:0]  low_reg;
   logic        core_rst_reg;
   logic        in_ready_reg;
   logic        busy_reg;
   logic [15:0] loaded_len_reg;
   logic        overflow_reg;

   logic [15:0] mem [1 << DEPTH_LOG2];

   logic                  accept;
   logic                  len_is_zero;
   logic                  word_fits;
   logic                  last_word;
   logic [15:0]           sat_len;
   logic                  wr_en;
   logic [DEPTH_LOG2-1:0] wr_addr;
   logic [15:0]           wr_data;
   logic [CW-1:0]         pc_ext;
   logic [CW-1:0]         len_ext;
   logic                  pc_in_range;

   assign accept = in_valid && in_ready_reg;

   // Decode handshake conditions and the memory write for the current byte.
   always_comb begin
      len_is_zero = ({in_data, len_reg[7:0]} == 16'd0);
      word_fits   = ({1'b0, wptr_reg} < DEPTH_W);
      last_word   = ((wptr_reg + 16'd1) == len_reg);
      // The length is clamped to the memory depth; words past the end are dropped.
      sat_len     = ({1'b0, len_reg} > DEPTH_W) ? DEPTH_W[15:0] : len_reg;
      wr_en       = (state_reg == S_INS_HI) && accept && word_fits;
      wr_addr     = wptr_reg[DEPTH_LOG2-1:0];
      wr_data     = {in_data, low_reg};
   end

   // Loader state machine; every status output is registered here.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg      <= S_IDLE;
         len_reg        <= 16'd0;
         wptr_reg       <= 16'd0;
         low_reg        <= 8'd0;
         core_rst_reg   <= 1'b1;
         in_ready_reg   <= 1'b0;
         busy_reg       <= 1'b1;
         loaded_len_reg <= 16'd0;
         overflow_reg   <= 1'b0;
      end else begin
         case (state_reg)
            S_IDLE: begin
               if (load_start) begin
                  state_reg    <= S_LEN_LO;
                  in_ready_reg <= 1'b1;
                  overflow_reg <= 1'b0;
               end
            end
            S_LEN_LO: begin
               if (accept) begin
                  len_reg[7:0] <= in_data;
                  state_reg    <= S_LEN_HI;
               end
            end
            S_LEN_HI: begin
               if (accept) begin
                  len_reg[15:8] <= in_data;
                  if (len_is_zero) begin
                     // An empty image releases the core straight away.
                     state_reg      <= S_RUN;
                     loaded_len_reg <= 16'd0;
                     core_rst_reg   <= 1'b0;
                     busy_reg       <= 1'b0;
                     in_ready_reg   <= 1'b0;
                  end else begin
                     wptr_reg  <= 16'd0;
                     state_reg <= S_INS_LO;
                  end
               end
            end
            S_INS_LO: begin
               if (accept) begin
                  low_reg   <= in_data;
                  state_reg <= S_INS_HI;
               end
            end
            S_INS_HI: begin
               if (accept) begin
                  // Oversized images are still consumed in full so the host
                  // stream stays byte-aligned; the excess words are discarded.
                  if (!word_fits) begin
                     overflow_reg <= 1'b1;
                  end
                  wptr_reg <= wptr_reg + 16'd1;
                  if (last_word) begin
                     state_reg      <= S_RUN;
                     loaded_len_reg <= sat_len;
                     core_rst_reg   <= 1'b0;
                     busy_reg       <= 1'b0;
                     in_ready_reg   <= 1'b0;
                  end else begin
                     state_reg <= S_INS_LO;
                  end
               end
            end
            S_RUN: begin
               if (load_start) begin
                  // A reload holds the core in reset again, but the old
                  // length stays in force until the new image has arrived.
                  state_reg    <= S_LEN_LO;
                  core_rst_reg <= 1'b1;
                  busy_reg     <= 1'b1;
                  in_ready_reg <= 1'b1;
                  overflow_reg <= 1'b0;
               end
            end
            default: begin
               state_reg    <= S_IDLE;
               core_rst_reg <= 1'b1;
               busy_reg     <= 1'b1;
               in_ready_reg <= 1'b0;
            end
         endcase
      end
   end

   // Instruction memory write port; the contents are deliberately not reset.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   // Fetch path: asynchronous read, gated by a full-width range check on pc.
   always_comb begin
      pc_ext      = CW'(pc);
      len_ext     = CW'(loaded_len_reg);
      pc_in_range = (pc_ext < len_ext);
      instruction = pc_in_range ? mem[pc[DEPTH_LOG2-1:0]] : FILL;
   end

   assign in_ready   = in_ready_reg;
   assign core_rst   = core_rst_reg;
   assign loaded_len = loaded_len_reg;
   assign overflow   = overflow_reg;
   assign busy       = busy_reg;

endmodule

// File: tb/tb_prog_loader.sv
// Testbench for prog_loader: directed images followed by randomized images.
// Expected responses come from a word-level model of the loaded program
// and are queued for a monitor that compares them against the DUT outputs.
module tb_prog_loader;

   localparam int          BITNESS = 64;
   localparam int          DL      = 2;
   localparam int          DEPTH   = 1 << DL;
   localparam logic [15:0] FILL    = 16'hF1F0;

   logic               clk;
   logic               rst;
   logic               load_start;
   logic               in_valid;
   logic [7:0]         in_data;
   logic               in_ready;
   logic [BITNESS-1:0] pc;
   logic [15:0]        instruction;
   logic               core_rst;
   logic [15:0]        loaded_len;
   logic               overflow;
   logic               busy;

   prog_loader #(
      .BITNESS(BITNESS),
      .DEPTH_LOG2(DL),
      .FILL(FILL)
   ) dut (
      .clk(clk),
      .rst(rst),
      .load_start(load_start),
      .in_valid(in_valid),
      .in_data(in_data),
      .in_ready(in_ready),
      .pc(pc),
      .instruction(instruction),
      .core_rst(core_rst),
      .loaded_len(loaded_len),
      .overflow(overflow),
      .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- reference model ----------------
   logic [15:0] m_mem [DEPTH];
   logic [15:0] m_len;
   logic        m_ovf;
   logic [15:0] img_q [$];

   function automatic logic [15:0] m_fetch(input logic [63:0] p);
      if (p < 64'(m_len)) return m_mem[int'(p)];
      return FILL;
   endfunction

   // ---------------- scoreboard ----------------
   typedef struct {
      string       name;
      int          sel;
      logic [63:0] exp;
   } chk_t;

   typedef struct {
      int          cyc;
      logic [15:0] len;
      logic        ovf;
   } run_t;

   chk_t sb_q [$];
   run_t run_q [$];
   int   checks = 0;
   int   errors = 0;
   int   tmo_cnt = 0;

   task automatic expect_out(input string name, input int sel, input logic [63:0] exp);
      chk_t e;
      e.name = name;
      e.sel  = sel;
      e.exp  = exp;
      sb_q.push_back(e);
   endtask

   // Monitor: drain queued expectations each cycle and check every release of core_rst.
   chk_t        mon_e;
   run_t        mon_r;
   logic [63:0] mon_act;
   logic        prev_core_rst;

   always @(negedge clk) begin
      while (sb_q.size() > 0) begin
         mon_e = sb_q.pop_front();
         case (mon_e.sel)
            0:       mon_act = 64'(instruction);
            1:       mon_act = 64'(core_rst);
            2:       mon_act = 64'(loaded_len);
            3:       mon_act = 64'(overflow);
            4:       mon_act = 64'(busy);
            5:       mon_act = 64'(in_ready);
            6:       mon_act = 64'(tmo_cnt);
            default: mon_act = 64'(run_q.size());
         endcase
         checks++;
         if (mon_act !== mon_e.exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", mon_e.name, mon_act, mon_e.exp, cyc);
         end
      end
      if (prev_core_rst === 1'b1 && core_rst === 1'b0) begin
         checks++;
         if (run_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_run: got core_rst release at cycle %0d expected none", cyc);
         end else begin
            mon_r = run_q.pop_front();
            if (cyc != mon_r.cyc) begin
               errors++;
               $display("FAIL run_latency: got cycle %0d expected cycle %0d", cyc, mon_r.cyc);
            end
            checks++;
            if (loaded_len !== mon_r.len) begin
               errors++;
               $display("FAIL run_loaded_len: got %0d expected %0d", loaded_len, mon_r.len);
            end
            checks++;
            if (overflow !== mon_r.ovf) begin
               errors++;
               $display("FAIL run_overflow: got %0b expected %0b", overflow, mon_r.ovf);
            end
         end
      end
      prev_core_rst = core_rst;
   end

   // ---------------- stimulus tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_load();
      load_start = 1'b1;
      tick();
      load_start = 1'b0;
      expect_out("start_core_rst", 1, 64'd1);
      expect_out("start_busy", 4, 64'd1);
      expect_out("start_in_ready", 5, 64'd1);
      expect_out("start_overflow", 3, 64'd0);
      expect_out("start_loaded_len", 2, 64'(m_len));
   endtask

   // Present one byte until accepted; returns just after the accepting edge.
   task automatic send_byte(input logic [7:0] b, input bit throttle, input bit noise);
      int n;
      if (throttle) begin
         in_valid   = 1'b0;
         load_start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
         tick();
      end
      in_valid   = 1'b1;
      in_data    = b;
      load_start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      expect_out("load_core_rst", 1, 64'd1);
      expect_out("load_busy", 4, 64'd1);
      expect_out("load_in_ready", 5, 64'd1);
      n = 0;
      forever begin
         @(negedge clk);
         if (in_ready === 1'b1) break;
         n++;
         if (n > 20) begin
            tmo_cnt++;
            expect_out("byte_timeout", 6, 64'd0);
            break;
         end
         @(posedge clk);
         #1;
      end
      @(posedge clk);
      #1;
      in_valid   = 1'b0;
      load_start = 1'b0;
   endtask

   // Model update once the final byte has been accepted.
   task automatic finish_model(input int n);
      for (int i = 0; i < n; i++) begin
         if (i < DEPTH) m_mem[i] = img_q[i];
      end
      m_len = (n > DEPTH) ? 16'(DEPTH) : 16'(n);
      m_ovf = (n > DEPTH);
      begin
         run_t r;
         r.cyc = cyc;
         r.len = m_len;
         r.ovf = m_ovf;
         run_q.push_back(r);
      end
      expect_out("run_core_rst", 1, 64'd0);
      expect_out("run_busy", 4, 64'd0);
      expect_out("run_in_ready", 5, 64'd0);
      expect_out("run_len", 2, 64'(m_len));
      expect_out("run_ovf", 3, 64'(m_ovf));
   endtask

   task automatic load_image(input bit throttle, input bit noise);
      int n;
      n = img_q.size();
      start_load();
      send_byte(8'(n), throttle, noise);
      send_byte(8'(n >> 8), throttle, noise);
      for (int i = 0; i < n; i++) begin
         send_byte(img_q[i][7:0], throttle, noise);
         send_byte(img_q[i][15:8], throttle, noise);
      end
      finish_model(n);
   endtask

   task automatic fetch(input logic [63:0] p);
      pc = p;
      expect_out($sformatf("fetch_pc_%0h", p), 0, 64'(m_fetch(p)));
      tick();
   endtask

   // Host bytes offered while running must not be taken.
   task automatic run_idle_check();
      in_valid = 1'b1;
      in_data  = 8'hA5;
      for (int i = 0; i < 3; i++) begin
         expect_out("run_no_ready", 5, 64'd0);
         expect_out("run_hold_core", 1, 64'd0);
         tick();
      end
      in_valid = 1'b0;
   endtask

   task automatic image1();
      img_q.delete();
      img_q.push_back(16'h1234);
      img_q.push_back(16'h5678);
      img_q.push_back(16'h9ABC);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

   // ---------------- test sequence ----------------
   initial begin
      rst        = 1'b1;
      load_start = 1'b0;
      in_valid   = 1'b0;
      in_data    = 8'h00;
      pc         = '0;
      m_len      = 16'd0;
      m_ovf      = 1'b0;
      for (int i = 0; i < DEPTH; i++) m_mem[i] = 16'h0000;

      // Reset state
      tick();
      tick();
      expect_out("rst_core_rst", 1, 64'd1);
      expect_out("rst_in_ready", 5, 64'd0);
      expect_out("rst_loaded_len", 2, 64'd0);
      expect_out("rst_overflow", 3, 64'd0);
      expect_out("rst_busy", 4, 64'd1);
      rst = 1'b0;
      tick();
      expect_out("idle_in_ready", 5, 64'd0);
      fetch(64'd0);

      // 1: basic image
      image1();
      load_image(1'b0, 1'b0);
      for (int i = 0; i < 4; i++) fetch(64'(i));
      run_idle_check();

      // 2: throttled host, same image
      load_image(1'b1, 1'b0);
      for (int i = 0; i < 4; i++) fetch(64'(i));

      // 3: zero-length image
      img_q.delete();
      load_image(1'b0, 1'b0);
      for (int i = 0; i < 3; i++) fetch(64'(i));

      // 4: image longer than memory
      img_q.delete();
      for (int i = 1; i <= 6; i++) img_q.push_back(16'(i));
      load_image(1'b0, 1'b0);
      for (int i = 0; i < 6; i++) fetch(64'(i));
      expect_out("ovf_sticky", 3, 64'd1);
      tick();

      // 5: reload from RUN
      img_q.delete();
      img_q.push_back(16'hBEEF);
      load_image(1'b0, 1'b0);
      fetch(64'd0);
      fetch(64'd1);

      // 6: reset mid-load, then a full load
      image1();
      start_load();
      send_byte(8'h03, 1'b0, 1'b0);
      send_byte(8'h00, 1'b0, 1'b0);
      send_byte(8'h34, 1'b0, 1'b0);
      rst = 1'b1;
      tick();
      expect_out("abort_core_rst", 1, 64'd1);
      expect_out("abort_loaded_len", 2, 64'd0);
      expect_out("abort_in_ready", 5, 64'd0);
      expect_out("abort_busy", 4, 64'd1);
      rst   = 1'b0;
      m_len = 16'd0;
      m_ovf = 1'b0;
      tick();
      fetch(64'd0);
      load_image(1'b0, 1'b0);
      fetch(64'd2);
      fetch(64'h8000_0000_0000_0000);
      fetch(64'h0000_0001_0000_0001);

      // Randomized images with throttling and ignored load_start pulses
      for (int it = 0; it < 15; it++) begin
         int n;
         n = $urandom_range(0, 7);
         img_q.delete();
         for (int i = 0; i < n; i++) img_q.push_back(16'($urandom));
         load_image(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         for (int k = 0; k < 4; k++) fetch(64'($urandom_range(0, 7)));
         fetch({1'b1, 63'($urandom_range(0, 3))});
      end

      tick();
      expect_out("run_q_drained", 7, 64'd0);
      expect_out("no_timeouts", 6, 64'd0);
      tick();
      tick();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
